// File: rtl/max7000_pkg.sv
// Shared types and constants for the MAX7000 device model.
// Imported by the configuration loader and its word assembler.
package max7000_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam int DEFAULT_TOTAL_BITS = 15033;

    // Per-LAB configuration layout
    localparam int LAB_PTERMS      = 80;
    localparam int PTERM_BITS      = 88;
    localparam int LAB_MACROCELLS  = 16;
    localparam int MACROCELL_BITS  = 13;
    localparam int LAB_BITS        = LAB_PTERMS * PTERM_BITS
                                   + LAB_MACROCELLS * MACROCELL_BITS;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/config_word_assembler.sv
// Shadow shift register, word counter and running XOR for the loader.
// The last data word contributes only its non-padding high bits.
module config_word_assembler
    import max7000_pkg::*;
#(
    parameter int TOTAL_BITS = DEFAULT_TOTAL_BITS,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [WORD_WIDTH-1:0] word_in,
    output logic [TOTAL_BITS-1:0] shadow,
    output logic [WORD_WIDTH-1:0] csum,
    output logic                  last_word
);

    localparam int NUM_WORDS = ceil_div(TOTAL_BITS, WORD_WIDTH);
    localparam int PAD_BITS  = NUM_WORDS * WORD_WIDTH - TOTAL_BITS;
    localparam int KEEP_BITS = WORD_WIDTH - PAD_BITS;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);

    logic [TOTAL_BITS-1:0] shadow_q, shadow_d;
    logic [WORD_WIDTH-1:0] csum_q, csum_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign last_word = (cnt_q == CNT_W'(NUM_WORDS - 1));
    assign shadow    = shadow_q;
    assign csum      = csum_q;

    always_comb begin
        shadow_d = shadow_q;
        csum_d   = csum_q;
        cnt_d    = cnt_q;
        if (clear) begin
            csum_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            csum_d = csum_q ^ word_in;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_word) begin
                shadow_d = {shadow_q[TOTAL_BITS-KEEP_BITS-1:0],
                            word_in[WORD_WIDTH-1 -: KEEP_BITS]};
            end else begin
                shadow_d = {shadow_q[TOTAL_BITS-WORD_WIDTH-1:0], word_in};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shadow_q <= '0;
            csum_q   <= '0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            csum_q   <= csum_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/max7000_config_loader.sv
// Streams configuration words into a shadow register, verifies the XOR
// checksum one cycle after it arrives, then commits to the device bus.
module max7000_config_loader
    import max7000_pkg::*;
#(
    parameter int TOTAL_BITS = DEFAULT_TOTAL_BITS,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  busy,
    output logic                  config_valid,
    output logic                  config_error,
    output logic [TOTAL_BITS-1:0] bitstream
);

    state_e                state_q, state_d;
    logic                  pending_q, pending_d;
    logic                  match_q, match_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;
    logic [TOTAL_BITS-1:0] bits_q, bits_d;

    logic                  accept;
    logic                  shift_en;
    logic                  last_word;
    logic [TOTAL_BITS-1:0] shadow;
    logic [WORD_WIDTH-1:0] csum;

    config_word_assembler #(
        .TOTAL_BITS (TOTAL_BITS),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_asm (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (start),
        .shift_en  (shift_en),
        .word_in   (word_in),
        .shadow    (shadow),
        .csum      (csum),
        .last_word (last_word)
    );

    assign busy         = (state_q == ST_LOAD) || (state_q == ST_CSUM);
    // The compare cycle after the checksum keeps busy high but refuses words.
    assign word_ready   = busy && !pending_q;
    assign accept       = word_valid && word_ready;
    assign config_valid = valid_q;
    assign config_error = error_q;
    assign bitstream    = bits_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        match_d   = match_q;
        valid_d   = valid_q;
        error_d   = error_q;
        bits_d    = bits_q;
        shift_en  = 1'b0;
        if (start) begin
            state_d   = ST_LOAD;
            pending_d = 1'b0;
            error_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        shift_en = 1'b1;
                        if (last_word) state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (pending_q) begin
                        pending_d = 1'b0;
                        if (match_q) begin
                            state_d = ST_DONE;
                            bits_d  = shadow;
                            valid_d = 1'b1;
                        end else begin
                            state_d = ST_ERROR;
                            error_d = 1'b1;
                        end
                    end else if (accept) begin
                        pending_d = 1'b1;
                        match_d   = (word_in == csum);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            match_q   <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            bits_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            match_q   <= match_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            bits_q    <= bits_d;
        end
    end

endmodule

// File: tb/tb_max7000_config_loader.sv
// Directed bench for the configuration loader with a result scoreboard.
module tb_max7000_config_loader;

    localparam int TB = 20;
    localparam int WW = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [WW-1:0] word_in;
    logic          word_valid;
    logic          word_ready;
    logic          busy;
    logic          config_valid;
    logic          config_error;
    logic [TB-1:0] bitstream;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [TB-1:0] bits;
        logic          v;
        logic          e;
    } exp_t;

    exp_t sb[$];

    max7000_config_loader #(
        .TOTAL_BITS (TB),
        .WORD_WIDTH (WW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .busy         (busy),
        .config_valid (config_valid),
        .config_error (config_error),
        .bitstream    (bitstream)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [WW-1:0] w, input int gap);
        word_valid = 1'b0;
        repeat (gap) step();
        word_valid = 1'b1;
        word_in    = w;
        check("ready", word_ready, 1);
        step();
        word_valid = 1'b0;
    endtask

    task automatic expect_result(input logic [TB-1:0] bits, input logic v,
                                 input logic e);
        exp_t x;
        x.bits = bits;
        x.v    = v;
        x.e    = e;
        sb.push_back(x);
    endtask

    task automatic wait_commit();
        exp_t x;
        for (int i = 0; i < 8 && busy; i++) step();
        check("commit_timeout", busy, 0);
        check("sb_level", sb.size(), 1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check("bitstream", bitstream, x.bits);
            check("config_valid", config_valid, x.v);
            check("config_error", config_error, x.e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, word_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, config_valid, 0);
        check({tag, "_error"}, config_error, 0);
        check({tag, "_bits"}, bitstream, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        word_valid = 1'b0;
        word_in    = '0;
        step();
        step();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        step();
        check("idle_ready", word_ready, 0);

        // Bad checksum straight after reset
        pulse_start();
        check("start_ready", word_ready, 1);
        check("start_busy", busy, 1);
        send(8'hA5, 0);
        send(8'h3C, 0);
        send(8'hF0, 0);
        expect_result(20'h0, 1'b0, 1'b1);
        send(8'h68, 0);
        wait_commit();
        check("error_ready", word_ready, 0);

        // Good load at full rate with latency check
        pulse_start();
        check("restart_error_clr", config_error, 0);
        send(8'hA5, 0);
        send(8'h3C, 0);
        send(8'hF0, 0);
        expect_result(20'hA53CF, 1'b1, 1'b0);
        send(8'h69, 0);
        check("busy_at_n", busy, 1);
        check("ready_at_n", word_ready, 0);
        step();
        check("busy_at_n1", busy, 0);
        wait_commit();
        check("done_ready", word_ready, 0);

        // Words offered while DONE are ignored
        word_valid = 1'b1;
        word_in    = 8'h77;
        step();
        word_valid = 1'b0;
        check("done_ignore_busy", busy, 0);
        check("done_ignore_bits", bitstream, 20'hA53CF);

        // Abandoned load then full restart
        pulse_start();
        check("abandon_valid0", config_valid, 1);
        send(8'h11, 0);
        send(8'h22, 0);
        pulse_start();
        check("abandon_valid1", config_valid, 1);
        check("abandon_bits", bitstream, 20'hA53CF);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h30, 0);
        expect_result(20'h11223, 1'b1, 1'b0);
        send(8'h03, 0);
        check("abandon_valid2", config_valid, 1);
        wait_commit();

        // Random bubbles in the word stream
        pulse_start();
        send(8'hA5, $urandom_range(0, 2));
        send(8'h3C, $urandom_range(0, 2));
        send(8'hF0, $urandom_range(0, 2));
        expect_result(20'hA53CF, 1'b1, 1'b0);
        send(8'h69, $urandom_range(0, 2));
        wait_commit();

        // Reset after the second data word
        pulse_start();
        send(8'h11, 0);
        send(8'h22, 0);
        reset_n = 1'b0;
        step();
        check_reset_outputs("midrst");
        reset_n    = 1'b1;
        word_valid = 1'b1;
        word_in    = 8'h30;
        step();
        word_in = 8'h03;
        step();
        word_valid = 1'b0;
        step();
        check("midrst_no_commit_v", config_valid, 0);
        check("midrst_no_commit_b", bitstream, 0);

        // Start coincident with an accepted word
        pulse_start();
        send(8'hA5, 0);
        start      = 1'b1;
        word_valid = 1'b1;
        word_in    = 8'hFF;
        step();
        start      = 1'b0;
        word_valid = 1'b0;
        check("coincide_busy", busy, 1);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h30, 0);
        expect_result(20'h11223, 1'b1, 1'b0);
        send(8'h03, 0);
        wait_commit();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
